// File: rtl/instr_fetch_stage.sv
// ----------------------------------------------------------------------------
// instr_fetch_stage
//   Fetch stage plus IF/ID register. Owns the 64-bit PC, keeps at most one
//   instruction-memory request outstanding, and hands {instruction, pc} to
//   decode through a valid/ready slot. A one-entry buffer catches a response
//   that arrives while decode is stalled. A redirect from execute flushes the
//   slot and buffer and restarts fetch at the target; a response that was
//   already in flight for the wrong path is drained and discarded.
//
//   Optional feature macro: FETCH_MISALIGN_CHK_EN
//     defined   : a redirect to a target with pc[1:0] != 0 flushes, keeps the
//                 PC, stops fetching and raises a sticky misalign_fault.
//     undefined : redirect targets are forced to word alignment and
//                 misalign_fault is tied low.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   imem_req_*        fetch request (valid/ready, 64-bit address = pc)
//   imem_rsp_*        fetch response (no backpressure, max 1 outstanding)
//   redirect_*        taken branch/jump target from execute
//   id_valid/id_ready decode slot handshake
//   id_instruction    instruction in the slot (NOP_INSTR when id_valid = 0)
//   id_pc             PC of id_instruction
//   misalign_fault    sticky misaligned-redirect flag
// ----------------------------------------------------------------------------
module instr_fetch_stage #(
   parameter logic [63:0] RESET_PC  = 64'h0,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [63:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instruction,
   output logic [63:0] id_pc,
   output logic        misalign_fault
);

   typedef enum logic [2:0] {
      S_REQ   = 3'd0,
      S_WAIT  = 3'd1,
      S_HOLD  = 3'd2,
      S_DRAIN = 3'd3
`ifdef FETCH_MISALIGN_CHK_EN
      , S_FAULT = 3'd4
`endif
   } state_t;

   state_t      state_r;
   logic [63:0] pc_r;
   logic        id_valid_r;
   logic [31:0] id_instr_r;
   logic [63:0] id_pc_r;
   logic [31:0] buf_instr_r;
   logic [63:0] buf_pc_r;
`ifdef FETCH_MISALIGN_CHK_EN
   logic        fault_r;
`endif

   logic        req_fire_s;
   logic        slot_free_s;
   logic [63:0] pc_next_s;
   logic [63:0] redirect_target_s;
   state_t      redirect_state_s;

   // Request handshake, slot availability, sequential PC and redirect target.
   always_comb begin
      req_fire_s        = (state_r == S_REQ) && imem_req_ready;
      slot_free_s       = !id_valid_r || id_ready;
      pc_next_s         = pc_r + 64'd4;   // wraps modulo 2^64
      redirect_target_s = {redirect_pc[63:2], 2'b00};
   end

   // Where fetch goes after a redirect: if a request is (or is being) issued
   // and its response has not been seen yet, DRAIN must swallow it first.
   always_comb begin
      redirect_state_s = S_REQ;
      case (state_r)
         S_REQ:   redirect_state_s = req_fire_s ? S_DRAIN : S_REQ;
         S_WAIT:  redirect_state_s = imem_rsp_valid ? S_REQ : S_DRAIN;
         S_DRAIN: redirect_state_s = imem_rsp_valid ? S_REQ : S_DRAIN;
         S_HOLD:  redirect_state_s = S_REQ;
         default: redirect_state_s = S_REQ;
      endcase
   end

`ifndef FETCH_MISALIGN_CHK_EN
   // Without the alignment check the low target bits are simply dropped.
   logic unused_low_bits_s;
   assign unused_low_bits_s = ^redirect_pc[1:0];
`endif

   // Fetch FSM, PC, IF/ID slot and skid buffer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= S_REQ;
         pc_r        <= RESET_PC;
         id_valid_r  <= 1'b0;
         id_instr_r  <= NOP_INSTR;
         id_pc_r     <= 64'h0;
         buf_instr_r <= NOP_INSTR;
         buf_pc_r    <= 64'h0;
`ifdef FETCH_MISALIGN_CHK_EN
         fault_r     <= 1'b0;
`endif
      end else if (redirect_valid) begin
         // Redirect beats everything, including a same-cycle id_ready or
         // response: the slot is emptied and never refilled this cycle.
         id_valid_r <= 1'b0;
         id_instr_r <= NOP_INSTR;
`ifdef FETCH_MISALIGN_CHK_EN
         if ((state_r == S_FAULT) || (redirect_pc[1:0] != 2'b00)) begin
            state_r <= S_FAULT;
            fault_r <= 1'b1;
         end else begin
            pc_r    <= redirect_target_s;
            state_r <= redirect_state_s;
         end
`else
         pc_r    <= redirect_target_s;
         state_r <= redirect_state_s;
`endif
      end else begin
         // Decode took the slot; later assignments refill it if possible.
         if (id_ready) begin
            id_valid_r <= 1'b0;
            id_instr_r <= NOP_INSTR;
         end
         case (state_r)
            S_REQ: begin
               if (req_fire_s) begin
                  state_r <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_rsp_valid) begin
                  pc_r <= pc_next_s;
                  if (slot_free_s) begin
                     id_valid_r <= 1'b1;
                     id_instr_r <= imem_rsp_data;
                     id_pc_r    <= pc_r;
                     state_r    <= S_REQ;
                  end else begin
                     buf_instr_r <= imem_rsp_data;
                     buf_pc_r    <= pc_r;
                     state_r     <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               // Slot is known full here, so id_ready frees it for the buffer.
               if (id_ready) begin
                  id_valid_r <= 1'b1;
                  id_instr_r <= buf_instr_r;
                  id_pc_r    <= buf_pc_r;
                  state_r    <= S_REQ;
               end
            end
            S_DRAIN: begin
               if (imem_rsp_valid) begin
                  state_r <= S_REQ;
               end
            end
`ifdef FETCH_MISALIGN_CHK_EN
            S_FAULT: state_r <= S_FAULT;   // parked until reset
`endif
            default: state_r <= S_REQ;
         endcase
      end
   end

   assign imem_req_valid = (state_r == S_REQ);
   assign imem_req_addr  = pc_r;
   assign id_valid       = id_valid_r;
   assign id_instruction = id_instr_r;
   assign id_pc          = id_pc_r;
`ifdef FETCH_MISALIGN_CHK_EN
   assign misalign_fault = fault_r;
`else
   assign misalign_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_stage
//   Directed bench for instr_fetch_stage. A small memory model answers each
//   accepted request after mem_lat extra cycles with instr_of(addr). Inputs
//   are driven on the falling edge; outputs are checked on the falling edge.
// ----------------------------------------------------------------------------
module tb_instr_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = 64'h0;
   logic        id_valid;
   logic        id_ready = 1'b0;
   logic [31:0] id_instruction;
   logic [63:0] id_pc;
   logic        misalign_fault;

   int errors = 0;
   int checks = 0;
   int mem_lat = 0;

   logic        pend;
   logic [63:0] pend_addr;
   int          cnt;
   logic [63:0] req_q[$];
   logic [63:0] acc_pc_q[$];
   logic [31:0] acc_ins_q[$];

   instr_fetch_stage dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_instruction (id_instruction),
      .id_pc          (id_pc),
      .misalign_fault (misalign_fault)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [63:0] a);
      return a[31:0] ^ a[63:32] ^ 32'h5A5A_0003;
   endfunction

   // Memory model: always ready, one response mem_lat cycles after acceptance.
   initial begin
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      pend = 1'b0; pend_addr = 64'h0; cnt = 0;
      forever begin
         @(negedge clk);
         #1;
         imem_rsp_valid = 1'b0;
         if (reset) begin
            pend = 1'b0;
         end else if (pend) begin
            if (cnt == 0) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = instr_of(pend_addr);
               pend = 1'b0;
            end else begin
               cnt = cnt - 1;
            end
         end
         if (!reset && imem_req_valid && imem_req_ready) begin
            pend = 1'b1; pend_addr = imem_req_addr; cnt = mem_lat;
            req_q.push_back(imem_req_addr);
         end
      end
   end

   // Record every instruction decode takes (flushed slots are not taken).
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!reset && id_valid && id_ready && !redirect_valid) begin
            acc_pc_q.push_back(id_pc);
            acc_ins_q.push_back(id_instruction);
         end
      end
   end

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 64'h0;
      id_ready = 1'b0; mem_lat = 0;
      ticks(2);
      req_q.delete(); acc_pc_q.delete(); acc_ins_q.delete();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      ticks(2);
      checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL rst_req_valid: got %0b want 1", imem_req_valid); end
      checks++; if (imem_req_addr !== 64'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", imem_req_addr); end
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_id_valid: got %0b want 0", id_valid); end
      checks++; if (id_instruction !== NOP) begin errors++; $display("FAIL rst_nop: got %h want %h", id_instruction, NOP); end
      checks++; if (id_pc !== 64'h0) begin errors++; $display("FAIL rst_id_pc: got %h want 0", id_pc); end
      checks++; if (misalign_fault !== 1'b0) begin errors++; $display("FAIL rst_fault: got %0b want 0", misalign_fault); end
      reset = 1'b0; id_ready = 1'b1;
      ticks(4);
      checks++; if (id_valid !== 1'b1 || id_pc !== 64'h4) begin errors++; $display("FAIL rst_run: got v=%0b pc=%h want v=1 pc=4", id_valid, id_pc); end
      // Asynchronous reset between clock edges.
      #2 reset = 1'b1;
      #1;
      checks++; if (id_valid !== 1'b0 || id_instruction !== NOP) begin errors++; $display("FAIL async_rst_slot: got v=%0b ins=%h want v=0 ins=%h", id_valid, id_instruction, NOP); end
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0) begin errors++; $display("FAIL async_rst_req: got v=%0b a=%h want v=1 a=0", imem_req_valid, imem_req_addr); end
   endtask

   task automatic test_sequential();
      do_reset();
      id_ready = 1'b1;
      ticks(1);
      checks++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL seq_wait: got idv=%0b reqv=%0b want 0 0", id_valid, imem_req_valid); end
      ticks(1);
      checks++; if (id_valid !== 1'b1 || id_pc !== 64'h0 || id_instruction !== instr_of(64'h0)) begin errors++; $display("FAIL seq_first: got v=%0b pc=%h ins=%h want v=1 pc=0 ins=%h", id_valid, id_pc, id_instruction, instr_of(64'h0)); end
      ticks(8);
      checks++; if (acc_pc_q.size() != 4) begin errors++; $display("FAIL seq_count: got %0d want 4", acc_pc_q.size()); end
      if (acc_pc_q.size() >= 4) begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (acc_pc_q[i] !== 64'(4 * i) || acc_ins_q[i] !== instr_of(64'(4 * i))) begin
               errors++; $display("FAIL seq_item%0d: got pc=%h ins=%h want pc=%h ins=%h", i, acc_pc_q[i], acc_ins_q[i], 64'(4 * i), instr_of(64'(4 * i)));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      id_ready = 1'b1;
      ticks(6);
      checks++; if (id_valid !== 1'b1 || id_pc !== 64'h8) begin errors++; $display("FAIL bp_setup: got v=%0b pc=%h want v=1 pc=8", id_valid, id_pc); end
      id_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         ticks(1);
         checks++;
         if (id_valid !== 1'b1 || id_pc !== 64'h8 || id_instruction !== instr_of(64'h8) || imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL bp_hold%0d: got v=%0b pc=%h ins=%h reqv=%0b want v=1 pc=8 reqv=0", i, id_valid, id_pc, id_instruction, imem_req_valid);
         end
      end
      id_ready = 1'b1;
      ticks(1);
      checks++; if (id_valid !== 1'b1 || id_pc !== 64'hC || id_instruction !== instr_of(64'hC)) begin errors++; $display("FAIL bp_release: got v=%0b pc=%h ins=%h want v=1 pc=c", id_valid, id_pc, id_instruction); end
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h10) begin errors++; $display("FAIL bp_next_req: got v=%0b a=%h want v=1 a=10", imem_req_valid, imem_req_addr); end
      checks++; if (req_q.size() != 4) begin errors++; $display("FAIL bp_req_count: got %0d want 4", req_q.size()); end
   endtask

   task automatic test_redirect_wait();
      do_reset();
      id_ready = 1'b1; mem_lat = 3;
      ticks(1);
      redirect_valid = 1'b1; redirect_pc = 64'h100;
      ticks(1);
      redirect_valid = 1'b0; mem_lat = 0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin
            errors++; $display("FAIL rw_drain%0d: got reqv=%0b idv=%0b want 0 0", i, imem_req_valid, id_valid);
         end
         ticks(1);
      end
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h100) begin errors++; $display("FAIL rw_req: got v=%0b a=%h want v=1 a=100", imem_req_valid, imem_req_addr); end
      ticks(2);
      checks++; if (id_valid !== 1'b1 || id_pc !== 64'h100 || id_instruction !== instr_of(64'h100)) begin errors++; $display("FAIL rw_id: got v=%0b pc=%h ins=%h want v=1 pc=100", id_valid, id_pc, id_instruction); end
      checks++; if (acc_pc_q.size() != 0) begin errors++; $display("FAIL rw_stale: got %0d taken want 0", acc_pc_q.size()); end
      checks++; if (req_q.size() != 2 || req_q[req_q.size() - 1] !== 64'h100) begin errors++; $display("FAIL rw_req_log: got n=%0d want n=2 last=100", req_q.size()); end
   endtask

   task automatic test_redirect_collide();
      do_reset();
      id_ready = 1'b1;
      ticks(2);
      id_ready = 1'b0;
      ticks(1);
      checks++; if (id_valid !== 1'b1 || id_pc !== 64'h0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL rc_setup: got v=%0b pc=%h reqv=%0b want v=1 pc=0 reqv=0", id_valid, id_pc, imem_req_valid); end
      id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h200;
      ticks(1);
      redirect_valid = 1'b0;
      checks++; if (id_valid !== 1'b0 || id_instruction !== NOP) begin errors++; $display("FAIL rc_flush: got v=%0b ins=%h want v=0 ins=%h", id_valid, id_instruction, NOP); end
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h200) begin errors++; $display("FAIL rc_req: got v=%0b a=%h want v=1 a=200", imem_req_valid, imem_req_addr); end
      ticks(2);
      checks++; if (id_valid !== 1'b1 || id_pc !== 64'h200 || id_instruction !== instr_of(64'h200)) begin errors++; $display("FAIL rc_id: got v=%0b pc=%h ins=%h want v=1 pc=200", id_valid, id_pc, id_instruction); end
      checks++; if (acc_pc_q.size() != 0) begin errors++; $display("FAIL rc_stale: got %0d taken want 0", acc_pc_q.size()); end
   endtask

   task automatic test_wrap();
      do_reset();
      id_ready = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      ticks(1);
      redirect_valid = 1'b0;
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL wrap_drain: got reqv=%0b want 0", imem_req_valid); end
      ticks(1);
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_top: got v=%0b a=%h want v=1 a=fffffffffffffffc", imem_req_valid, imem_req_addr); end
      ticks(2);
      checks++; if (id_valid !== 1'b1 || id_pc !== 64'hFFFF_FFFF_FFFF_FFFC || id_instruction !== instr_of(64'hFFFF_FFFF_FFFF_FFFC)) begin errors++; $display("FAIL wrap_id: got v=%0b pc=%h ins=%h", id_valid, id_pc, id_instruction); end
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0) begin errors++; $display("FAIL wrap_zero: got v=%0b a=%h want v=1 a=0", imem_req_valid, imem_req_addr); end
   endtask

   task automatic test_misalign();
      do_reset();
      id_ready = 1'b1;
      ticks(2);
      redirect_valid = 1'b1; redirect_pc = 64'h102;
      ticks(1);
      redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      checks++; if (imem_req_addr !== 64'h4) begin errors++; $display("FAIL mis_pc_kept: got %h want 4", imem_req_addr); end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (misalign_fault !== 1'b1 || imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin
            errors++; $display("FAIL mis_fault%0d: got f=%0b reqv=%0b idv=%0b want 1 0 0", i, misalign_fault, imem_req_valid, id_valid);
         end
         ticks(1);
      end
`else
      checks++; if (misalign_fault !== 1'b0 || id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL mis_flush: got f=%0b idv=%0b reqv=%0b want 0 0 0", misalign_fault, id_valid, imem_req_valid); end
      ticks(1);
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h100) begin errors++; $display("FAIL mis_align_req: got v=%0b a=%h want v=1 a=100", imem_req_valid, imem_req_addr); end
      ticks(2);
      checks++; if (id_valid !== 1'b1 || id_pc !== 64'h100 || misalign_fault !== 1'b0) begin errors++; $display("FAIL mis_align_id: got v=%0b pc=%h f=%0b want v=1 pc=100 f=0", id_valid, id_pc, misalign_fault); end
`endif
      do_reset();
      checks++; if (misalign_fault !== 1'b0) begin errors++; $display("FAIL mis_clear: got %0b want 0", misalign_fault); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect_wait();
      test_redirect_collide();
      test_wrap();
      test_misalign();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
